imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit instruction words the target memory holds.
REQ-002 SHALL have parameter ADDR_W, default 6, word-address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
REQ-006 SHALL have port in_data, input, 8, byte-stream data.
REQ-007 SHALL have port in_valid, input, 1, in_data holds a byte.
REQ-008 SHALL have port in_ready, output, 1, loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both high.
REQ-009 SHALL have port wr_en, output, 1, one-cycle instruction-memory write strobe.
REQ-010 SHALL have port wr_addr, output, ADDR_W, word address of the write.
REQ-011 SHALL have port wr_data, output, 32, instruction word to write.
REQ-012 SHALL have port cpu_reset, output, 1, held high to keep the processor in reset until the load completes.
REQ-013 SHALL have port done, output, 1, level; the load completed successfully.
REQ-014 SHALL have port error, output, 1, level; the load was aborted.
REQ-015 SHALL have port words_loaded, output, ADDR_W+1, count of words written in the current or last load.

Function
REQ-016 SHALL implement states IDLE, LEN, DATA, CSUM, DONE and ERROR.
- IDLE/DONE/ERROR + start -> LEN.
- LEN: accept 1 length byte N; N in 1..DEPTH -> DATA; otherwise -> ERROR.
- DATA: after the 4N-th byte -> CSUM when IMEM_LOADER_CHECKSUM_EN is defined, else -> DONE.
- CSUM: accept 1 byte; match -> DONE, mismatch -> ERROR.
REQ-017 SHALL drive in_ready high only in LEN, DATA and CSUM.
REQ-018 SHALL assemble each word big-endian: the first byte goes to wr_data[31:24], the fourth to [7:0].
REQ-019 SHALL pulse wr_en for exactly one cycle, the cycle after the fourth byte of a word is accepted, with the complete word on wr_data.
REQ-020 SHALL start wr_addr at 0 for the first word and increment it by 1 per word.
REQ-021 SHALL not let wr_addr wrap; words beyond N are never written.
REQ-022 SHALL increment words_loaded with each wr_en and clear it to 0 on start.
REQ-023 SHALL clear done and error on start.
REQ-024 SHALL hold cpu_reset high in every state except DONE, and drive it low in the cycle after the final wr_en (or after the checksum byte when IMEM_LOADER_CHECKSUM_EN is defined).
REQ-025 SHALL ignore in_valid while in_ready is low.
REQ-026 SHALL ignore start while in LEN, DATA or CSUM.
REQ-027 SHALL tolerate stalls: a gap of any length in in_valid leaves all state unchanged.

Reset
REQ-028 SHALL, when reset is sampled high, set state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, words_loaded=0, done=0, error=0 and cpu_reset=1.
REQ-029 SHALL, on reset mid-load, abandon the load with no further wr_en; memory contents already written are left as they are.

Configuration
REQ-030 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, keep an 8-bit running sum (mod 256) of the N bytes and the 4N payload bytes, and compare it against the trailing CSUM byte.
REQ-031 SHALL, without IMEM_LOADER_CHECKSUM_EN defined, omit the CSUM state and the checksum register, and the stream ends after 4N bytes.

Structure
REQ-032 SHALL place the state enum and the LEN_W/BYTE_W constants in shared package mips32_pkg.
REQ-033 SHALL be a single module; no sub-module is required.

Verification
REQ-034 SHALL cover: start, N=2, bytes 20 08 00 05 20 09 00 07 -> wr_en at addr 0 with 0x20080005 and at addr 1 with 0x20090007; done=1; cpu_reset=0; words_loaded=2.
REQ-035 SHALL cover: start, N=0 -> error=1, no wr_en, cpu_reset=1; the same applies for N=65 with DEPTH=64.
REQ-036 SHALL cover: N=1 with in_valid toggled at random -> exactly one wr_en, data 0x08000000 for bytes 08 00 00 00.
REQ-037 SHALL cover: reset asserted after the 6th byte of an N=2 load -> no wr_en after reset, state IDLE, cpu_reset=1.
REQ-038 SHALL cover, with IMEM_LOADER_CHECKSUM_EN: N=1, bytes 20 08 00 05, CSUM 0x2E -> done=1; CSUM 0x2F -> error=1, cpu_reset=1.
REQ-039 SHALL cover: start pulsed mid-DATA -> ignored, and the load completes normally.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared definitions for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing checksum state.
package mips32_pkg;

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone,
    StError
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader. Receives a length byte N, then 4N payload
// bytes (big-endian words). Each word goes out on a one-cycle write strobe. The CPU is
// held in reset until the load completes.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 sum byte
// covering N and all payload bytes.
module imem_loader
  import mips32_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned         CntW   = ADDR_W + 1;
  localparam logic [CntW-1:0]     OneCnt = 1;

  loader_state_e state_q, state_d;

  logic             accept;
  logic             start_ok;
  logic             len_ok;
  logic             word_last_byte;
  logic             load_last_word;
  logic [LEN_W-1:0] len_byte;

  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_q, word_d;
  logic [CntW-1:0]   len_q, len_d;
  logic [CntW-1:0]   words_q, words_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              cpu_reset_q, cpu_reset_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic              csum_ok;
  assign csum_ok = (in_data == sum_q);
`endif

  assign accept         = in_valid & in_ready;
  assign start_ok       = start & ((state_q == StIdle) || (state_q == StDone) ||
                                   (state_q == StError));
  assign len_byte       = in_data;
  assign len_ok         = (len_byte != '0) && (32'(len_byte) <= DEPTH);
  assign word_last_byte = (byte_cnt_q == 2'd3);
  assign load_last_word = ((words_q + OneCnt) == len_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: if (start) state_d = StLen;
      StLen:  if (accept) state_d = len_ok ? StData : StError;
      StData: begin
        if (accept && word_last_byte && load_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum: if (accept) state_d = csum_ok ? StDone : StError;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Per-state outputs
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      StLen, StData: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum:        in_ready = 1'b1;
`endif
      StDone:        done     = 1'b1;
      StError:       error    = 1'b1;
      default:       ;
    endcase
  end

  // Datapath next-state: word assembly, write strobe, counters
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    len_d      = len_q;
    words_d    = words_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    if (start_ok) begin
      byte_cnt_d = '0;
      words_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d      = '0;
`endif
    end

    if (accept && (state_q == StLen)) begin
      len_d = CntW'(len_byte);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d = sum_q + in_data;
`endif
    end

    if (accept && (state_q == StData)) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (word_last_byte) begin
        // Address comes from the pre-increment count, so the first word lands at 0
        wr_en_d   = 1'b1;
        wr_data_d = {word_q, in_data};
        wr_addr_d = words_q[ADDR_W-1:0];
        words_d   = words_q + OneCnt;
      end else begin
        word_d = {word_q[15:0], in_data};
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d = sum_q + in_data;
`endif
    end

    // Keep the CPU in reset through the final write strobe
    cpu_reset_d = (state_d != StDone) || wr_en_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q  <= '0;
      word_q      <= '0;
      len_q       <= '0;
      words_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      len_q       <= len_d;
      words_q     <= words_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_reset    = cpu_reset_q;
  assign words_loaded = words_q;

endmodule
